// File: rtl/ncr5380_lite_if.sv
// CPU-side and SCSI-side signal bundle for the ncr5380_lite initiator.
// slave = controller view, master = CPU plus target view.
interface ncr5380_lite_if;
   logic       cs;
   logic       we;
   logic [2:0] rs;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       dack;
   logic       dreq;
   logic       irq;
   logic       scsi_rst;
   logic       scsi_sel;
   logic       scsi_atn;
   logic       scsi_ack;
   logic [7:0] scsi_dout;
   logic       scsi_bsy;
   logic       scsi_req;
   logic       scsi_msg;
   logic       scsi_cd;
   logic       scsi_io;
   logic [7:0] scsi_din;

   modport slave (
      input  cs, we, rs, wdata, dack,
      input  scsi_bsy, scsi_req, scsi_msg, scsi_cd, scsi_io, scsi_din,
      output rdata, dreq, irq,
      output scsi_rst, scsi_sel, scsi_atn, scsi_ack, scsi_dout
   );

   modport master (
      output cs, we, rs, wdata, dack,
      output scsi_bsy, scsi_req, scsi_msg, scsi_cd, scsi_io, scsi_din,
      input  rdata, dreq, irq,
      input  scsi_rst, scsi_sel, scsi_atn, scsi_ack, scsi_dout
   );
endinterface

// File: rtl/ncr5380_lite.sv
// Reduced NCR 5380 initiator: PIO bus control plus pseudo-DMA REQ/ACK engine.
// Define NCR_IRQ_EN to build the interrupt flag and irq output.
module ncr5380_lite #(
   parameter int ACK_HOLD = 2
) (
   input logic            clk,
   input logic            reset,
   ncr5380_lite_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, WREQ, WCPU, ACK, WREL} state_t;

   localparam logic [7:0] HOLD_LAST = 8'(ACK_HOLD - 1);

   state_t     state;
   logic [7:0] odr;
   logic [7:0] idr;
   logic [7:0] icr;
   logic [7:0] mr;
   logic [2:0] tcr;
   logic       rx_mode;
   logic       fsm_ack;
   logic       dreq_r;
   logic [7:0] hold_cnt;
   logic       irq_flag;
   logic [7:0] rdata_c;

   logic wr;
   logic phase_match;
   logic dma_send;
   logic bsy_abort;
   logic mr_abort;
   logic dack_hit;

   assign wr          = bus.cs & bus.we;
   assign phase_match = ({bus.scsi_msg, bus.scsi_cd, bus.scsi_io} == tcr);
   assign dma_send    = (state != IDLE) & ~rx_mode;
   assign bsy_abort   = (state != IDLE) & ~bus.scsi_bsy;
   assign mr_abort    = wr & (bus.rs == 3'd2) & ~bus.wdata[1];
   assign dack_hit    = bus.dack & (state == WCPU);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         icr <= 8'h00;
         mr  <= 8'h00;
         tcr <= 3'b000;
      end else if (wr) begin
         case (bus.rs)
            3'd1:    icr <= bus.wdata & 8'h97;
            3'd2:    mr  <= bus.wdata;
            3'd3:    tcr <= bus.wdata[2:0];
            default: ;
         endcase
      end
   end

   // ODR is shared between CPU writes and DMA send; the CPU loses while sending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         odr      <= 8'h00;
         idr      <= 8'h00;
         rx_mode  <= 1'b0;
         fsm_ack  <= 1'b0;
         dreq_r   <= 1'b0;
         hold_cnt <= 8'h00;
      end else begin
         if (wr && bus.rs == 3'd0 && !dma_send)
            odr <= bus.wdata;
         if (bsy_abort || (state != IDLE && mr_abort)) begin
            state   <= IDLE;
            fsm_ack <= 1'b0;
            dreq_r  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (wr && mr[1] && (bus.rs == 3'd5 || bus.rs == 3'd7)) begin
                     state   <= WREQ;
                     rx_mode <= (bus.rs == 3'd7);
                  end
               end
               WREQ: begin
                  if (bus.scsi_req) begin
                     if (phase_match) begin
                        if (rx_mode)
                           idr <= bus.scsi_din;
                        dreq_r <= 1'b1;
                        state  <= WCPU;
                     end else begin
                        dreq_r <= 1'b0;
                        state  <= IDLE;
                     end
                  end
               end
               WCPU: begin
                  if (bus.dack) begin
                     if (!rx_mode)
                        odr <= bus.wdata;
                     dreq_r  <= 1'b0;
                     fsm_ack <= 1'b1;
                     state   <= ACK;
                  end
               end
               ACK: begin
                  if (!bus.scsi_req) begin
                     hold_cnt <= 8'h00;
                     state    <= WREL;
                  end
               end
               WREL: begin
                  if (hold_cnt == HOLD_LAST) begin
                     fsm_ack <= 1'b0;
                     state   <= WREQ;
                  end else begin
                     hold_cnt <= hold_cnt + 8'h01;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef NCR_IRQ_EN
   logic ph_abort;
   assign ph_abort = (state == WREQ) & bus.scsi_req & ~phase_match;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         irq_flag <= 1'b0;
      else if (bsy_abort || ph_abort)
         irq_flag <= 1'b1;
      else if (bus.cs && !bus.we && bus.rs == 3'd7)
         irq_flag <= 1'b0;
   end
`else
   assign irq_flag = 1'b0;
`endif

   always_comb begin
      rdata_c = 8'h00;
      if (dack_hit && rx_mode) begin
         rdata_c = idr;
      end else begin
         case (bus.rs)
            3'd0: rdata_c = bus.scsi_din;
            3'd1: rdata_c = icr;
            3'd2: rdata_c = mr;
            3'd3: rdata_c = {5'b00000, tcr};
            3'd4: rdata_c = {icr[7], bus.scsi_bsy, bus.scsi_req, bus.scsi_msg,
                             bus.scsi_cd, bus.scsi_io, icr[2], 1'b0};
            3'd5: rdata_c = {1'b0, dreq_r, 1'b0, irq_flag, phase_match,
                             2'b00, icr[1]};
            3'd6: rdata_c = idr;
            default: rdata_c = 8'h00;
         endcase
      end
   end

   assign bus.rdata     = rdata_c;
   assign bus.dreq      = dreq_r;
   assign bus.irq       = irq_flag;
   assign bus.scsi_rst  = icr[7];
   assign bus.scsi_sel  = icr[2];
   assign bus.scsi_atn  = icr[1];
   assign bus.scsi_ack  = icr[4] | fsm_ack;
   assign bus.scsi_dout = (icr[0] || dma_send) ? odr : 8'h00;
endmodule
